// File: rtl/panel_io_pkg.sv
// Shared constants for the front-panel input reader: channel count,
// read-word field layout and read FSM encoding.
package panel_io_pkg;

    localparam int NUM_CH   = 4;
    localparam int RISE_LSB = 0;
    localparam int FALL_LSB = RISE_LSB + NUM_CH;
    localparam int OVF_LSB  = FALL_LSB + NUM_CH;
    localparam int RD_W     = OVF_LSB + NUM_CH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } rd_state_t;

endpackage

// File: rtl/input_debounce.sv
// One front-panel channel: 2-flop synchronizer followed by a run-length
// debouncer that publishes a stable level plus edge strobes.
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta       <= 1'b0;
            sync       <= 1'b0;
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            meta       <= pin;
            sync       <= meta;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            // Any agreeing sample restarts the run, so only an unbroken
            // stretch of DEBOUNCE_CYCLES mismatches is accepted.
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt < LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt        <= '0;
                level      <= sync;
                rise_pulse <= sync;
                fall_pulse <= ~sync;
            end
        end
    end

endmodule

// File: rtl/panel_input_reader.sv
// Four debounced front-panel inputs with sticky edge/overflow event bits
// that are read and cleared atomically through a req/ack handshake.
module panel_input_reader
    import panel_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] bnc_in,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic [RD_W-1:0]   rd_data
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk       (clk),
            .rst_n     (rst_n),
            .pin       (bnc_in[i]),
            .level     (level[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i])
        );
    end

    rd_state_t         state;
    logic [NUM_CH-1:0] evt_rise;
    logic [NUM_CH-1:0] evt_fall;
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] ovf_hit;
    logic [RD_W-1:0]   capture;

    // A pulse landing on an already-set event bit means an edge was lost.
    always_comb begin
        ovf_hit = (rise_pulse & evt_rise) | (fall_pulse & evt_fall);
        capture = '0;
        capture[RISE_LSB +: NUM_CH] = evt_rise | rise_pulse;
        capture[FALL_LSB +: NUM_CH] = evt_fall | fall_pulse;
        capture[OVF_LSB  +: NUM_CH] = ovf | ovf_hit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rd_ack   <= 1'b0;
            rd_data  <= '0;
            evt_rise <= '0;
            evt_fall <= '0;
            ovf      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_req) begin
                        // Capture and clear in the same edge so no pulse
                        // can fall between the snapshot and the clear.
                        rd_data  <= capture;
                        rd_ack   <= 1'b1;
                        evt_rise <= '0;
                        evt_fall <= '0;
                        ovf      <= '0;
                        state    <= ST_ACK;
                    end else begin
                        rd_ack   <= 1'b0;
                        evt_rise <= evt_rise | rise_pulse;
                        evt_fall <= evt_fall | fall_pulse;
                        ovf      <= ovf | ovf_hit;
                    end
                end
                ST_ACK: begin
                    rd_ack   <= 1'b0;
                    evt_rise <= evt_rise | rise_pulse;
                    evt_fall <= evt_fall | fall_pulse;
                    ovf      <= ovf | ovf_hit;
                    state    <= ST_IDLE;
                end
                default: begin
                    rd_ack <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_panel_input_reader.sv
// Bench for panel_input_reader: directed scenarios plus a randomized run
// against a window-based reference model of debounce and event reads.
module tb_panel_input_reader;

    localparam int D     = 4;
    localparam int HMAX  = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  bnc_in = 4'b0;
    logic [3:0]  level, rise_pulse, fall_pulse;
    logic        rd_req = 1'b0;
    logic        rd_ack;
    logic [11:0] rd_data;

    int n_checks = 0;
    int n_err    = 0;

    panel_input_reader #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bnc_in    (bnc_in),
        .level     (level),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .rd_req    (rd_req),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    // Reference model: pin samples per edge; a channel flips when the last D
    // synchronized samples (pin two edges earlier) all disagree with it.
    logic [3:0]  hist [0:HMAX-1];
    int          cyc = 0;
    int          last_rst = 0;
    logic [3:0]  m_level = '0, m_rise = '0, m_fall = '0;
    logic [3:0]  m_er = '0, m_ef = '0, m_ov = '0;
    logic        m_ack = 1'b0, m_busy = 1'b0;
    logic [11:0] m_data = '0;

    function automatic logic [3:0] hist_at(int k);
        if (k < 0 || k >= HMAX) return 4'b0;
        return hist[k];
    endfunction

    task automatic tick();
        logic [3:0] b, pr, pf, nr, nf, hit;
        logic       rq, rn, flip;
        b  = bnc_in;
        rq = rd_req;
        rn = rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (!rn) begin
            if (cyc < HMAX) hist[cyc] = 4'b0;
            last_rst = cyc;
            m_level = '0; m_rise = '0; m_fall = '0;
            m_er = '0; m_ef = '0; m_ov = '0;
            m_ack = 1'b0; m_busy = 1'b0; m_data = '0;
        end else begin
            if (cyc < HMAX) hist[cyc] = b;
            pr = m_rise;
            pf = m_fall;
            for (int ch = 0; ch < 4; ch++) begin
                flip = (cyc - D + 1 > last_rst);
                for (int t = 0; t < D; t++)
                    if (hist_at(cyc - 2 - t)[ch] == m_level[ch]) flip = 1'b0;
                nr[ch] = flip & ~m_level[ch];
                nf[ch] = flip & m_level[ch];
                if (flip) m_level[ch] = ~m_level[ch];
            end
            hit = (pr & m_er) | (pf & m_ef);
            if (!m_busy && rq) begin
                m_data = {m_ov | hit, m_ef | pf, m_er | pr};
                m_er = '0; m_ef = '0; m_ov = '0;
                m_ack = 1'b1; m_busy = 1'b1;
            end else begin
                m_ov = m_ov | hit;
                m_er = m_er | pr;
                m_ef = m_ef | pf;
                m_ack = 1'b0; m_busy = 1'b0;
            end
            m_rise = nr;
            m_fall = nf;
        end
    endtask

    task automatic settle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_read(output logic ack, output logic [11:0] data);
        rd_req = 1'b1;
        tick();
        ack  = rd_ack;
        data = rd_data;
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bnc_in = '0; rd_req = 1'b0;
        settle(3);
        n_checks += 5;
        if (level !== 4'h0) begin n_err++; $display("FAIL reset_level got=%h exp=0", level); end
        if (rise_pulse !== 4'h0) begin n_err++; $display("FAIL reset_rise got=%h exp=0", rise_pulse); end
        if (fall_pulse !== 4'h0) begin n_err++; $display("FAIL reset_fall got=%h exp=0", fall_pulse); end
        if (rd_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%b exp=0", rd_ack); end
        if (rd_data !== 12'h000) begin n_err++; $display("FAIL reset_data got=%h exp=000", rd_data); end
        rst_n = 1'b1;
        settle(2);
    endtask

    task automatic test_rise_latency();
        bnc_in[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_checks++;
            if (k < 6 && (level[0] !== 1'b0 || rise_pulse[0] !== 1'b0)) begin
                n_err++; $display("FAIL latency_early edge=N+%0d level=%b rise=%b exp=0/0", k, level[0], rise_pulse[0]);
            end else if (k == 6 && (level[0] !== 1'b1 || rise_pulse[0] !== 1'b1)) begin
                n_err++; $display("FAIL latency_edge edge=N+6 level=%b rise=%b exp=1/1", level[0], rise_pulse[0]);
            end else if (k == 7 && (level[0] !== 1'b1 || rise_pulse[0] !== 1'b0)) begin
                n_err++; $display("FAIL latency_pulse_end edge=N+7 level=%b rise=%b exp=1/0", level[0], rise_pulse[0]);
            end
        end
    endtask

    task automatic test_glitch();
        logic ack; logic [11:0] data;
        do_read(ack, data);
        bnc_in[2] = 1'b1;
        settle(3);
        bnc_in[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if (level[2] !== 1'b0 || rise_pulse[2] !== 1'b0 || fall_pulse[2] !== 1'b0) begin
                n_err++; $display("FAIL glitch_ch2 level=%b rise=%b fall=%b exp=0/0/0", level[2], rise_pulse[2], fall_pulse[2]);
            end
        end
        do_read(ack, data);
        n_checks++;
        if (ack !== 1'b1 || data !== 12'h000) begin
            n_err++; $display("FAIL glitch_events ack=%b data=%h exp=1/000", ack, data);
        end
    endtask

    task automatic test_read_rise_fall();
        logic ack; logic [11:0] data;
        do_read(ack, data);
        bnc_in[1] = 1'b1; settle(10);
        bnc_in[1] = 1'b0; settle(10);
        rd_req = 1'b1;
        tick();
        n_checks++;
        if (rd_ack !== 1'b1 || rd_data !== 12'h022) begin
            n_err++; $display("FAIL read1 ack=%b data=%h exp=1/022", rd_ack, rd_data);
        end
        tick();
        n_checks++;
        if (rd_ack !== 1'b0 || rd_data !== 12'h022) begin
            n_err++; $display("FAIL read1_single ack=%b data=%h exp=0/022", rd_ack, rd_data);
        end
        tick();
        n_checks++;
        if (rd_ack !== 1'b1 || rd_data !== 12'h000) begin
            n_err++; $display("FAIL read2 ack=%b data=%h exp=1/000", rd_ack, rd_data);
        end
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        logic ack; logic [11:0] data;
        do_read(ack, data);
        bnc_in[3] = 1'b1; settle(10);
        bnc_in[3] = 1'b0; settle(10);
        bnc_in[3] = 1'b1; settle(10);
        do_read(ack, data);
        n_checks++;
        if (ack !== 1'b1 || data !== 12'h888) begin
            n_err++; $display("FAIL overflow_ch3 ack=%b data=%h exp=1/888", ack, data);
        end
        bnc_in[3] = 1'b0; settle(10);
    endtask

    task automatic test_capture_coincide();
        logic ack; logic [11:0] data;
        bnc_in[0] = 1'b0; settle(10);
        do_read(ack, data);
        bnc_in[0] = 1'b1;
        settle(6);
        n_checks++;
        if (rise_pulse[0] !== 1'b1) begin
            n_err++; $display("FAIL coincide_pulse got=%b exp=1", rise_pulse[0]);
        end
        rd_req = 1'b1;
        tick();
        n_checks++;
        if (rd_ack !== 1'b1 || rd_data !== 12'h001) begin
            n_err++; $display("FAIL coincide_read ack=%b data=%h exp=1/001", rd_ack, rd_data);
        end
        rd_req = 1'b0;
        tick();
        do_read(ack, data);
        n_checks++;
        if (ack !== 1'b1 || data !== 12'h000) begin
            n_err++; $display("FAIL coincide_next ack=%b data=%h exp=1/000", ack, data);
        end
    endtask

    task automatic test_reset_during_ack();
        rd_req = 1'b1;
        tick();
        n_checks++;
        if (rd_ack !== 1'b1) begin n_err++; $display("FAIL rst_ack_pre got=%b exp=1", rd_ack); end
        rd_req = 1'b0;
        rst_n  = 1'b0;
        tick();
        n_checks++;
        if (rd_ack !== 1'b0 || rd_data !== 12'h000 || level !== 4'h0 ||
            rise_pulse !== 4'h0 || fall_pulse !== 4'h0) begin
            n_err++; $display("FAIL rst_mid_ack ack=%b data=%h level=%h rise=%h fall=%h exp=all0",
                              rd_ack, rd_data, level, rise_pulse, fall_pulse);
        end
        tick();
        rst_n  = 1'b1;
        rd_req = 1'b1;
        tick();
        n_checks++;
        if (rd_ack !== 1'b1) begin n_err++; $display("FAIL rst_idle_after got=%b exp=1", rd_ack); end
        rd_req = 1'b0;
        settle(12);
    endtask

    task automatic test_reset_held_input();
        bnc_in = 4'hF;
        rst_n  = 1'b0;
        settle(2);
        rst_n  = 1'b1;
        for (int k = 1; k <= D + 2; k++) begin
            tick();
            n_checks++;
            if (k <= D + 1 && (level !== 4'h0 || rise_pulse !== 4'h0)) begin
                n_err++; $display("FAIL held_early k=%0d level=%h rise=%h exp=0/0", k, level, rise_pulse);
            end else if (k == D + 2 && (level !== 4'hF || rise_pulse !== 4'hF)) begin
                n_err++; $display("FAIL held_accept level=%h rise=%h exp=F/F", level, rise_pulse);
            end
        end
        bnc_in = 4'h0;
        settle(10);
    endtask

    task automatic test_random();
        int rst_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(11) == 0) bnc_in[$urandom_range(3)] ^= 1'b1;
            rd_req = ($urandom_range(3) == 0);
            if (rst_left > 0) begin
                rst_left--;
            end else if ($urandom_range(499) == 0) begin
                rst_left = $urandom_range(2, 3);
            end
            rst_n = (rst_left == 0);
            tick();
            n_checks++;
            if (level !== m_level || rise_pulse !== m_rise || fall_pulse !== m_fall ||
                rd_ack !== m_ack || (m_ack && rd_data !== m_data)) begin
                n_err++;
                $display("FAIL random cyc=%0d level=%h/%h rise=%h/%h fall=%h/%h ack=%b/%b data=%h/%h (got/exp)",
                         cyc, level, m_level, rise_pulse, m_rise, fall_pulse, m_fall,
                         rd_ack, m_ack, rd_data, m_data);
            end
        end
        rst_n = 1'b1;
        rd_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_glitch();
        test_read_rise_fall();
        test_overflow();
        test_capture_coincide();
        test_reset_during_ack();
        test_reset_held_input();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
